// File: rtl/write_back_if.sv
// -----------------------------------------------------------------------------
// write_back_if
// Bundles every non-clock/reset signal of the write_back sequencer.
//   slave  : the write_back block itself.
//   master : the surrounding pipeline / long-op units / register file.
// Signals:
//   pipe_write_enable/address/data  single-cycle pipeline result
//   long_valid/ready/address/data   multi-cycle result handshake into the FIFO
//   read_address_a/b, pending_a/b   hazard lookup against queued writes
//   stall_request                   ask the pipeline to freeze so the FIFO drains
//   write_enable/address/data       register file write port (registered)
// -----------------------------------------------------------------------------
interface write_back_if;
   logic        pipe_write_enable;
   logic [4:0]  pipe_write_address;
   logic [31:0] pipe_write_data;

   logic        long_valid;
   logic        long_ready;
   logic [4:0]  long_address;
   logic [31:0] long_data;

   logic [4:0]  read_address_a;
   logic [4:0]  read_address_b;
   logic        pending_a;
   logic        pending_b;

   logic        stall_request;

   logic        write_enable;
   logic [4:0]  write_address;
   logic [31:0] write_data;

   modport slave (
      input  pipe_write_enable, pipe_write_address, pipe_write_data,
      input  long_valid, long_address, long_data,
      output long_ready,
      input  read_address_a, read_address_b,
      output pending_a, pending_b,
      output stall_request,
      output write_enable, write_address, write_data
   );

   modport master (
      output pipe_write_enable, pipe_write_address, pipe_write_data,
      output long_valid, long_address, long_data,
      input  long_ready,
      output read_address_a, read_address_b,
      input  pending_a, pending_b,
      input  stall_request,
      input  write_enable, write_address, write_data
   );
endinterface

// File: rtl/write_back.sv
// -----------------------------------------------------------------------------
// write_back
// Write-port sequencer for the 32x32 register file. Pipeline results win the
// single write port; multi-cycle results are buffered in a DEPTH-entry FIFO and
// drain in cycles the pipeline leaves free. A pipeline write kills older queued
// writes to the same register so the newer value survives.
//
// Parameters:
//   DEPTH         FIFO entries (power of two, 2..8)
//   STARVE_LIMIT  consecutive pipeline-won cycles before a stall is requested
// Ports:
//   clk  system clock (posedge)
//   rst  asynchronous active-high reset
//   wb   write_back_if.slave, see the interface file for the signal list
// Configuration macro:
//   WRITE_BACK_STARVE_GUARD_EN  builds the STALL state and starvation counter;
//   without it stall_request is 0 and the FIFO drains only in idle cycles.
// -----------------------------------------------------------------------------
module write_back #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   write_back_if.slave wb
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   // Elaboration-time guard against unusable parameter values.
   if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_check
      $error("write_back: DEPTH must be a power of two in 2..8 and STARVE_LIMIT >= 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_STALL = 2'd2
   } state_t;

   // FIFO storage: address/data need no reset, only the live bits do.
   logic [4:0]       fifo_addr_q [DEPTH];
   logic [31:0]      fifo_data_q [DEPTH];
   logic [DEPTH-1:0] fifo_live_q;
   logic [DEPTH-1:0] fifo_live_d;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   logic             write_enable_q;
   logic [4:0]       write_address_q;
   logic [31:0]      write_data_q;

   state_t           state_q;

   logic             full;
   logic             empty;
   logic             long_ready;
   logic             push;
   logic             pipe_win;
   logic             pop;
   logic [DEPTH-1:0] match_a;
   logic [DEPTH-1:0] match_b;

   assign full       = (count_q == CNT_W'(DEPTH));
   assign empty      = (count_q == '0);
   // No push-on-full even when a pop frees a slot this cycle.
   assign long_ready = !full && !rst;
   assign push       = wb.long_valid && long_ready;
   // A pipeline write to r0 is treated as no write at all.
   assign pipe_win   = wb.pipe_write_enable && (wb.pipe_write_address != 5'd0);
   assign pop        = !pipe_win && !empty;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Per-entry live bit and hazard match. A push never lands on an occupied
   // slot, so the push term cannot collide with the kill/pop terms of a valid
   // entry; the freshly pushed entry is therefore never killed in its own cycle.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_comb begin
         fifo_live_d[gi] = fifo_live_q[gi];
         if (push && wr_ptr_q == PTR_W'(gi)) begin
            fifo_live_d[gi] = (wb.long_address != 5'd0);
         end else if (pop && rd_ptr_q == PTR_W'(gi)) begin
            fifo_live_d[gi] = 1'b0;
         end else if (pipe_win && fifo_addr_q[gi] == wb.pipe_write_address) begin
            fifo_live_d[gi] = 1'b0;
         end
      end
      assign match_a[gi] = fifo_live_q[gi] && (fifo_addr_q[gi] == wb.read_address_a);
      assign match_b[gi] = fifo_live_q[gi] && (fifo_addr_q[gi] == wb.read_address_b);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= wb.long_address;
         fifo_data_q[wr_ptr_q] <= wb.long_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_live_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         fifo_live_q <= fifo_live_d;
         count_q     <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   // Registered write port. A popped dead entry occupies the port for a cycle
   // with write_enable low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         write_enable_q  <= 1'b0;
         write_address_q <= '0;
         write_data_q    <= '0;
      end else if (pipe_win) begin
         write_enable_q  <= 1'b1;
         write_address_q <= wb.pipe_write_address;
         write_data_q    <= wb.pipe_write_data;
      end else if (pop) begin
         write_enable_q  <= fifo_live_q[rd_ptr_q];
         write_address_q <= fifo_addr_q[rd_ptr_q];
         write_data_q    <= fifo_data_q[rd_ptr_q];
      end else begin
         write_enable_q  <= 1'b0;
      end
   end

`ifdef WRITE_BACK_STARVE_GUARD_EN
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
   logic [STARVE_W-1:0] starve_q;
   logic                stall_q;

   // In WAIT every cycle is either a pop or a pipeline win, so counting wins
   // between pops is exactly the run of consecutive starved cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         starve_q <= '0;
         stall_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               starve_q <= '0;
               stall_q  <= 1'b0;
               if (push) state_q <= ST_WAIT;
            end
            ST_WAIT, ST_STALL: begin
               if (pop) begin
                  starve_q <= '0;
                  stall_q  <= 1'b0;
                  state_q  <= (count_d == '0) ? ST_IDLE : ST_WAIT;
               end else if (pipe_win && state_q == ST_WAIT) begin
                  if (starve_q == STARVE_W'(STARVE_LIMIT - 1)) begin
                     state_q  <= ST_STALL;
                     stall_q  <= 1'b1;
                     starve_q <= STARVE_W'(STARVE_LIMIT);
                  end else begin
                     starve_q <= starve_q + STARVE_W'(1);
                  end
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               starve_q <= '0;
               stall_q  <= 1'b0;
            end
         endcase
      end
   end

   assign wb.stall_request = stall_q;
`else
   // Occupancy tracking only; the pipeline is never asked to stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (push) state_q <= ST_WAIT;
            ST_WAIT: if (pop && count_d == '0) state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign wb.stall_request = 1'b0;
`endif

   assign wb.long_ready    = long_ready;
   assign wb.write_enable  = write_enable_q;
   assign wb.write_address = write_address_q;
   assign wb.write_data    = write_data_q;

   assign wb.pending_a = (wb.read_address_a != 5'd0) &&
                         ((|match_a) || (write_enable_q && write_address_q == wb.read_address_a));
   assign wb.pending_b = (wb.read_address_b != 5'd0) &&
                         ((|match_b) || (write_enable_q && write_address_q == wb.read_address_b));
endmodule

// File: tb/tb_write_back.sv
// -----------------------------------------------------------------------------
// tb_write_back
// Directed scenarios followed by random traffic, checked every cycle against
// a queue-based model of the write-back rules, plus literal expectations.
// -----------------------------------------------------------------------------
module tb_write_back;
   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   write_back_if wb ();

   write_back #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .wb  (wb)
   );

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
      bit          live;
   } ent_t;

   int          vectors = 0;
   int          miscompares = 0;
   ent_t        q[$];
   int          wins;
   bit          exp_we;
   logic [4:0]  exp_wa;
   logic [31:0] exp_wd;
   logic [31:0] rf [32];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_ready();
      return q.size() < DEPTH;
   endfunction

   function automatic bit m_pending(logic [4:0] x);
      if (x == 5'd0) return 1'b0;
      foreach (q[i]) if (q[i].live && q[i].a == x) return 1'b1;
      return exp_we && exp_wa == x;
   endfunction

   function automatic bit m_stall();
`ifdef WRITE_BACK_STARVE_GUARD_EN
      return q.size() != 0 && wins >= LIMIT;
`else
      return 1'b0;
`endif
   endfunction

   task automatic drive(bit pwe, logic [4:0] pa, logic [31:0] pd,
                        bit lv, logic [4:0] la, logic [31:0] ld,
                        logic [4:0] ra, logic [4:0] rb);
      wb.pipe_write_enable  = pwe;
      wb.pipe_write_address = pa;
      wb.pipe_write_data    = pd;
      wb.long_valid         = lv;
      wb.long_address       = la;
      wb.long_data          = ld;
      wb.read_address_a     = ra;
      wb.read_address_b     = rb;
   endtask

   // One clock: check combinational outputs, advance the model, take the
   // edge, then check the registered write port.
   task automatic step();
      bit   rdy;
      bit   pwin;
      ent_t h;
      #1;
      chk("long_ready", wb.long_ready, m_ready());
      chk("pending_a", wb.pending_a, m_pending(wb.read_address_a));
      chk("pending_b", wb.pending_b, m_pending(wb.read_address_b));
      chk("stall_request", wb.stall_request, m_stall());
      rdy  = m_ready();
      pwin = wb.pipe_write_enable && wb.pipe_write_address != 5'd0;
      if (pwin) begin
         exp_we = 1'b1;
         exp_wa = wb.pipe_write_address;
         exp_wd = wb.pipe_write_data;
         foreach (q[i]) if (q[i].a == wb.pipe_write_address) q[i].live = 1'b0;
         wins = (q.size() != 0) ? wins + 1 : 0;
      end else if (q.size() != 0) begin
         h      = q.pop_front();
         exp_we = h.live;
         exp_wa = h.a;
         exp_wd = h.d;
         wins   = 0;
      end else begin
         exp_we = 1'b0;
      end
      if (wb.long_valid && rdy)
         q.push_back('{a: wb.long_address, d: wb.long_data, live: wb.long_address != 5'd0});
      @(posedge clk);
      #1;
      chk("write_enable", wb.write_enable, exp_we);
      if (exp_we) begin
         chk("write_address", wb.write_address, exp_wa);
         chk("write_data", wb.write_data, exp_wd);
      end
      if (wb.write_enable) rf[wb.write_address] = wb.write_data;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_write_enable", wb.write_enable, 0);
      chk("rst_write_address", wb.write_address, 0);
      chk("rst_write_data", wb.write_data, 0);
      chk("rst_long_ready", wb.long_ready, 0);
      chk("rst_pending_a", wb.pending_a, 0);
      chk("rst_pending_b", wb.pending_b, 0);
      chk("rst_stall", wb.stall_request, 0);
      q.delete();
      wins   = 0;
      exp_we = 1'b0;
      exp_wa = '0;
      exp_wd = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      do_reset();

      // Pipeline write r5 = 0x1234, readable the next cycle.
      drive(1, 5, 32'h1234, 0, 0, 0, 0, 0);
      step();
      chk("t1_we", wb.write_enable, 1);
      chk("t1_addr", wb.write_address, 5);
      chk("t1_data", wb.write_data, 32'h1234);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("t1_rf_r5", rf[5], 32'h1234);

      // Long op r7 = 0xDEAD with idle pipeline: two edges to the write port.
      drive(0, 0, 0, 1, 7, 32'hDEAD, 7, 0);
      step();
      chk("t2_no_write_yet", wb.write_enable, 0);
      drive(0, 0, 0, 0, 0, 0, 7, 0);
      #1;
      chk("t2_pending_queued", wb.pending_a, 1);
      step();
      chk("t2_we", wb.write_enable, 1);
      chk("t2_addr", wb.write_address, 7);
      chk("t2_data", wb.write_data, 32'hDEAD);
      chk("t2_pending_out", wb.pending_a, 1);
      step();
      chk("t2_pending_done", wb.pending_a, 0);
      chk("t2_rf_r7", rf[7], 32'hDEAD);

      // Queued r3 = 0xAAAA killed by a newer pipeline r3 = 0xBBBB.
      drive(1, 9, 32'h99, 1, 3, 32'hAAAA, 3, 0);
      step();
      drive(1, 3, 32'hBBBB, 0, 0, 0, 3, 0);
      step();
      chk("t3_pipe_data", wb.write_data, 32'hBBBB);
      drive(0, 0, 0, 0, 0, 0, 3, 0);
      step();
      chk("t3_dead_no_write", wb.write_enable, 0);
      chk("t3_pending_clear", wb.pending_a, 0);
      chk("t3_rf_r3", rf[3], 32'hBBBB);

      // Fill the FIFO, then a push beside a pop is refused.
      drive(1, 10, 32'h10, 1, 11, 32'h1111, 0, 0);
      step();
      drive(1, 10, 32'h11, 1, 12, 32'h2222, 0, 0);
      step();
      chk("t4_full_ready", wb.long_ready, 0);
      drive(0, 0, 0, 1, 13, 32'h3333, 13, 0);
      step();
      chk("t4_pop_addr", wb.write_address, 11);
      chk("t4_ready_back", wb.long_ready, 1);
      drive(0, 0, 0, 0, 0, 0, 13, 0);
      step();
      chk("t4_pop2_addr", wb.write_address, 12);
      step();
      chk("t4_refused_no_write", wb.write_enable, 0);
      chk("t4_refused_not_pending", wb.pending_a, 0);

      // Continuous pipeline writes starve one queued entry.
      drive(1, 14, 32'h0, 1, 15, 32'h5555, 15, 0);
      step();
      for (int i = 0; i < LIMIT; i++) begin
         drive(1, 14, i + 1, 0, 0, 0, 15, 0);
         step();
      end
`ifdef WRITE_BACK_STARVE_GUARD_EN
      chk("t5_stall_up", wb.stall_request, 1);
`else
      chk("t5_stall_up", wb.stall_request, 0);
`endif
      chk("t5_still_pending", wb.pending_a, 1);
      drive(0, 0, 0, 0, 0, 0, 15, 0);
      step();
      chk("t5_pop_we", wb.write_enable, 1);
      chk("t5_pop_addr", wb.write_address, 15);
      chk("t5_pop_data", wb.write_data, 32'h5555);
      chk("t5_stall_down", wb.stall_request, 0);

      // Reset with two entries queued discards them.
      drive(1, 16, 32'h16, 1, 20, 32'h2020, 20, 21);
      step();
      drive(1, 17, 32'h17, 1, 21, 32'h2121, 20, 21);
      step();
      chk("t6_pre_we", wb.write_enable, 1);
      chk("t6_pre_pending", wb.pending_b, 1);
      do_reset();
      drive(0, 0, 0, 0, 0, 0, 20, 21);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t6_no_write", wb.write_enable, 0);
      end

      // Random traffic over a narrow address range to force collisions.
      for (int n = 0; n < 500; n++) begin
         bit pwe;
         pwe = ($urandom_range(99) < 55);
         if (wb.stall_request && $urandom_range(99) < 80) pwe = 1'b0;
         drive(pwe, 5'($urandom_range(7)), $urandom,
               ($urandom_range(99) < 50), 5'($urandom_range(7)), $urandom,
               5'($urandom_range(7)), 5'($urandom_range(7)));
         step();
         if (n == 250) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/write_back.md
# write_back

Write-port sequencer for the 32x32 general-purpose register file. It merges single-cycle results from the main pipeline with results from multi-cycle units (divider, multiplier) that arrive through a valid/ready handshake and are buffered in a small FIFO. It drives the register file's single write port from registered outputs, and reports which registers still have a queued write so the hazard logic can stall dependent reads.

## Interface
- DEPTH, 2: long-op FIFO entries; a power of two, 2..8.
- STARVE_LIMIT, 4: consecutive pipeline-won cycles before the FIFO head forces a stall.

- clock  input  1  system clock; all state updates on the posedge.
- reset  input  1  asynchronous, active-high; clears all state.
- pipe_write_enable  input  1  pipeline result valid this cycle.
- pipe_write_address  input  5  pipeline destination register.
- pipe_write_data  input  32  pipeline result.
- long_valid  input  1  long-op result offered.
- long_ready  output  1  FIFO can accept; equals !full && !reset.
- long_address  input  5  long-op destination register.
- long_data  input  32  long-op result.
- read_address_a  input  5  hazard lookup address, port a.
- read_address_b  input  5  hazard lookup address, port b.
- pending_a  output  1  a queued or output-stage write targets read_address_a.
- pending_b  output  1  the same check for read_address_b.
- stall_request  output  1  freeze the pipeline so the FIFO head can drain.
- write_enable  output  1  to the register file write port.
- write_address  output  5  to the register file write port.
- write_data  output  32  to the register file write port.

## Operation
- Long-op accept: a transfer occurs when long_valid && long_ready.
  - An entry {address, data, live=1} is pushed.
  - Address 0 is accepted but pushed with live=0, so it drains and never writes.
- Arbitration, evaluated each cycle:
  - pipe_write_enable with pipe_write_address != 0 always wins.
  - Otherwise the FIFO head, if one exists, is popped. The output write_enable equals the head's live bit.
  - A pipeline write to address 0 counts as no pipeline write.
- Ordering kill: a winning pipeline write clears live on every FIFO entry with the same address, so the newer pipeline value is never overwritten by an older queued value. Entries pushed in the same cycle are not killed.
- Full FIFO: long_ready=0 even if a pop occurs that cycle (no same-cycle push-on-full). Push and pop in the same cycle on a non-full FIFO are allowed.
- Starvation FSM:
  - States: IDLE (FIFO empty), WAIT (non-empty, head not popped), STALL.
  - IDLE -> WAIT on a push.
  - WAIT -> IDLE when the last entry pops.
  - WAIT counts consecutive cycles in which the pipeline wins. On reaching STARVE_LIMIT, WAIT -> STALL.
  - The counter resets to 0 on every pop.
  - In STALL, stall_request=1. The pipeline must present pipe_write_enable=0; if it does not, the pipeline still wins.
  - STALL -> WAIT or IDLE after the head pops, depending on the remaining count.
- pending_x is combinational: (x != 0) && (x matches a live FIFO entry, or write_enable && write_address == x).

## Timing
- Output registers load at posedge k. The register file captures the write at the following negedge, so data is readable in cycle k+1 without forwarding.
- Latency, pipeline: 1 cycle from input to write_* outputs.
- Latency, long op: at least 2 cycles (push edge, then pop edge loads the outputs).
- Reset values:
  - write_enable=0, write_address=0, write_data=0.
  - FIFO empty, FSM in IDLE, starvation counter 0.
  - stall_request=0, long_ready=0, pending_a=0, pending_b=0.
- Reset mid-operation discards all queued entries; no partial write is issued.
- The FIFO pointers wrap modulo DEPTH. The occupancy count is log2(DEPTH)+1 bits wide.

## Configuration
- WRITE_BACK_STARVE_GUARD_EN defined: the starvation FSM STALL state and counter are built as described above.
- Not defined: stall_request is tied to 0 and the counter is removed. The FIFO drains only in pipeline-idle cycles, and the FSM keeps only IDLE/WAIT for occupancy tracking.

## Test plan
- Pipeline write r5=0x1234 in cycle 0 -> write_enable=1, write_address=5, write_data=0x1234 after posedge 1. A read of r5 in cycle 2 returns 0x1234.
- Long-op r7=0xDEAD with pipeline idle -> write_* shows r7=0xDEAD two edges after the handshake. pending_a=1 for read_address_a=7 until the write completes.
- Long-op r3=0xAAAA queued, then pipeline writes r3=0xBBBB -> the queued entry drains with write_enable=0 and r3 ends as 0xBBBB.
- Push DEPTH=2 entries -> long_ready=0. A push attempt alongside a pop in the same cycle is refused; long_ready returns to 1 one cycle later.
- With the guard compiled in, run continuous pipeline writes and one queued entry -> stall_request=1 after 4 cycles. The entry pops one cycle after stall_request asserts, and stall_request drops the next cycle.
- Assert reset with 2 entries queued -> all outputs return to 0 immediately, and no write to either queued address is issued afterwards.
